dcp_cmd_scanner: RTL and testbench

- Receive-side responder for the debug control panel (DCP) command path.
- Sits between the UART RX byte stream (d_rx/vld_rx/rdy_rx) and the DCP command FSM, which is the initiator on req_rx/type_rx.
- Serves two request types: a single command character, or a hex number terminated by CR.
- Returns the result on din_rx/flag_rx with a one-cycle ack_rx.

---
 rtl/dcp_cmd_scanner_if.sv | 21 ++
 rtl/dcp_cmd_scanner.sv | 106 ++++++++++
 tb/tb_dcp_cmd_scanner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dcp_cmd_scanner_if.sv
// rtl/dcp_cmd_scanner_if.sv - UART byte stream and DCP request/response bundle for the command scanner
interface dcp_cmd_scanner_if;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic        req_rx;
  logic        type_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        ack_rx;

  modport master (
    output d_rx, vld_rx, req_rx, type_rx,
    input  rdy_rx, din_rx, flag_rx, ack_rx
  );

  modport slave (
    input  d_rx, vld_rx, req_rx, type_rx,
    output rdy_rx, din_rx, flag_rx, ack_rx
  );
endinterface

// File: rtl/dcp_cmd_scanner.sv
// rtl/dcp_cmd_scanner.sv - DCP receive-side scanner: returns one command char or a CR-terminated hex number
module dcp_cmd_scanner #(
  parameter int HEX_DIGITS = 8,
  parameter bit DROP_LF    = 1'b1
) (
  input logic            clk,
  input logic            rstn,
  dcp_cmd_scanner_if.slave bus
);
  localparam int AW = 4 * HEX_DIGITS;
  localparam int CW = $clog2(HEX_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_CHAR, WAIT_HEX, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          xfer;
  logic          is_hex;
  logic [3:0]    nib;
  logic [7:0]    up_byte;
  logic          is_lf;

  assign xfer  = bus.vld_rx && bus.rdy_rx;
  assign is_lf = DROP_LF && (bus.d_rx == 8'h0A);

  always_comb begin
    is_hex  = 1'b0;
    nib     = 4'h0;
    up_byte = bus.d_rx;
    if (bus.d_rx >= 8'h30 && bus.d_rx <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(bus.d_rx - 8'h30);
    end else if (bus.d_rx >= 8'h41 && bus.d_rx <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(bus.d_rx - 8'h37);
    end else if (bus.d_rx >= 8'h61 && bus.d_rx <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(bus.d_rx - 8'h57);
    end
    if (bus.d_rx >= 8'h61 && bus.d_rx <= 8'h7A) begin
      up_byte = bus.d_rx - 8'h20;
    end
  end

  // rdy_rx/ack_rx are registered alongside the state so neither depends on vld_rx
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      bus.rdy_rx  <= 1'b0;
      bus.ack_rx  <= 1'b0;
      bus.din_rx  <= 32'h0;
      bus.flag_rx <= 1'b0;
    end else begin
      bus.ack_rx <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_rx) begin
            acc        <= '0;
            cnt        <= '0;
            bus.rdy_rx <= 1'b1;
            state      <= bus.type_rx ? WAIT_HEX : WAIT_CHAR;
          end
        end
        WAIT_CHAR: begin
          if (xfer && !is_lf) begin
            bus.din_rx  <= {24'h0, up_byte};
            bus.flag_rx <= 1'b1;
            bus.rdy_rx  <= 1'b0;
            bus.ack_rx  <= 1'b1;
            state       <= DONE;
          end
        end
        WAIT_HEX: begin
          if (xfer) begin
            if (is_hex) begin
              // oldest digit falls off the top once HEX_DIGITS are held
              acc <= {acc[AW-5:0], nib};
              if (cnt < CW'(HEX_DIGITS)) cnt <= cnt + CW'(1);
            end else if (bus.d_rx == 8'h08) begin
              if (cnt != '0) begin
                acc <= acc >> 4;
                cnt <= cnt - CW'(1);
              end
            end else if (bus.d_rx == 8'h0D) begin
              bus.din_rx  <= 32'(acc);
              bus.flag_rx <= (cnt != '0);
              bus.rdy_rx  <= 1'b0;
              bus.ack_rx  <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          bus.rdy_rx <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcp_cmd_scanner.sv
// tb/tb_dcp_cmd_scanner.sv - table-driven self-checking bench for dcp_cmd_scanner
module tb_dcp_cmd_scanner;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  dcp_cmd_scanner_if bus();

  dcp_cmd_scanner #(.HEX_DIGITS(8), .DROP_LF(1'b1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         typ;
    logic [127:0] msg;
    int           len;
    logic [31:0]  din;
    logic         flag;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    bus.req_rx  = 1'b1;
    bus.type_rx = v.typ;
    @(negedge clk);
    bus.req_rx = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      n = 0;
      while (!bus.rdy_rx && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_rdy_b%0d", idx, i), {31'h0, bus.rdy_rx}, 32'h1);
      bus.d_rx   = v.msg[8*(v.len-1-i) +: 8];
      bus.vld_rx = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_ack_b%0d", idx, i), {31'h0, bus.ack_rx}, (i == v.len - 1) ? 32'h1 : 32'h0);
    end
    bus.vld_rx = 1'b0;
    chk($sformatf("v%0d_din", idx), bus.din_rx, v.din);
    chk($sformatf("v%0d_flag", idx), {31'h0, bus.flag_rx}, {31'h0, v.flag});
    chk($sformatf("v%0d_rdy_in_ack", idx), {31'h0, bus.rdy_rx}, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d_ack_once", idx), {31'h0, bus.ack_rx}, 32'h0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rdy"},  {31'h0, bus.rdy_rx},  32'h0);
    chk({name, "_ack"},  {31'h0, bus.ack_rx},  32'h0);
    chk({name, "_din"},  bus.din_rx,           32'h0);
    chk({name, "_flag"}, {31'h0, bus.flag_rx}, 32'h0);
  endtask

  initial begin
    int cyc, acks, xfers, bidx, ack_cyc0, ack_cyc1;
    logic prev_xfer;
    logic [31:0] ack_val[2];
    logic [15:0] ab;
    vec_t v5;

    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b0, 128'("p"),                          1,  32'h00000050, 1'b1};
    vecs[1]  = '{1'b0, 128'("\012D"),                      2,  32'h00000044, 1'b1};
    vecs[2]  = '{1'b0, 128'("z"),                          1,  32'h0000005A, 1'b1};
    vecs[3]  = '{1'b0, 128'("5"),                          1,  32'h00000035, 1'b1};
    vecs[4]  = '{1'b1, 128'("1f00 3c\015"),                8,  32'h001F003C, 1'b1};
    vecs[5]  = '{1'b1, 128'("\015"),                       1,  32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 128'("123456789A\015"),             11, 32'h3456789A, 1'b1};
    vecs[7]  = '{1'b1, 128'("12G3\0104\015"),              7,  32'h00000124, 1'b1};
    vecs[8]  = '{1'b1, 128'("\010\0107\015"),              4,  32'h00000007, 1'b1};
    vecs[9]  = '{1'b1, 128'("123456789\010\015"),          11, 32'h02345678, 1'b1};
    vecs[10] = '{1'b1, 128'("\010\015"),                   2,  32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 128'("ab\012\015"),                 4,  32'h000000AB, 1'b1};

    // Reset with live-looking inputs: nothing may leak out
    rstn        = 1'b0;
    bus.d_rx    = 8'h41;
    bus.vld_rx  = 1'b1;
    bus.req_rx  = 1'b1;
    bus.type_rx = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    bus.vld_rx = 1'b0;
    bus.req_rx = 1'b0;
    rstn       = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a hex request discards partial digits
    bus.req_rx  = 1'b1;
    bus.type_rx = 1'b1;
    @(negedge clk);
    bus.req_rx = 1'b0;
    ab = 16'h4142;
    for (int i = 0; i < 2; i++) begin
      bus.d_rx   = ab[8*(1-i) +: 8];
      bus.vld_rx = 1'b1;
      @(negedge clk);
    end
    bus.vld_rx = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rstn = 1'b1;
    v5 = '{1'b1, 128'("5\015"), 2, 32'h00000005, 1'b1};
    run_vec(12, v5);

    // req held high with vld held high: back-to-back char requests
    bus.req_rx  = 1'b1;
    bus.type_rx = 1'b0;
    bus.d_rx    = 8'h41;
    bus.vld_rx  = 1'b1;
    bidx = 0; acks = 0; xfers = 0; prev_xfer = 1'b0;
    ack_cyc0 = 0; ack_cyc1 = 0;
    ack_val[0] = 32'h0; ack_val[1] = 32'h0;
    for (cyc = 0; cyc < 30 && acks < 2; cyc++) begin
      @(negedge clk);
      if (bus.ack_rx && bus.rdy_rx) begin
        errors++;
        $display("FAIL b2b_ack_rdy_overlap: cycle %0d", cyc);
      end
      if (prev_xfer) begin
        xfers++;
        bidx++;
        bus.d_rx = 8'h41 + 8'(bidx);
        if (bidx >= 2) bus.vld_rx = 1'b0;
      end
      if (bus.ack_rx) begin
        if (acks == 0) ack_cyc0 = cyc; else ack_cyc1 = cyc;
        ack_val[acks] = bus.din_rx;
        acks++;
        if (acks == 2) bus.req_rx = 1'b0;
      end
      prev_xfer = bus.rdy_rx && bus.vld_rx;
    end
    bus.vld_rx = 1'b0;
    bus.req_rx = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd2);
    chk("b2b_xfers", 32'(xfers), 32'd2);
    chk("b2b_val0", ack_val[0], 32'h41);
    chk("b2b_val1", ack_val[1], 32'h42);
    chk("b2b_gap", 32'(ack_cyc1 - ack_cyc0), 32'd3);
    repeat (3) @(negedge clk);
    chk("b2b_idle_rdy", {31'h0, bus.rdy_rx}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
